// File: rtl/video_st_pkg.sv
// Shared types and constants for the Avalon-ST video packetizer.
package video_st_pkg;

  localparam int PKG_DATA_W = 24;

  // Avalon-ST video packet type nibble carried in the header beat.
  localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;

  // Beat layout stored in the FIFO, MSB first: {eop, sop, data}.
  typedef struct packed {
    logic                  eop;
    logic                  sop;
    logic [PKG_DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_TERM   = 3'd3,
    ST_DROP   = 3'd4
  } pkt_state_t;

  // Counter width for a count range of n values. The result is never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_st_fifo.sv
// Synchronous show-ahead FIFO. o_rdata presents the head entry whenever the FIFO is not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module video_st_fifo #(
  parameter int W  = 26,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (o_level == FULL_LVL);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write. The contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Read and write pointers. The extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/video_stream_packetizer.sv
// Converts a free-running camera pixel interface into Avalon-ST video packets. Frames that cannot be
// buffered are ended with a padded EOP beat, so a packet is never left open or corrupted.
module video_stream_packetizer
  import video_st_pkg::*;
#(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int FIFO_AW = 4
) (
  input  logic              pixel_clk_clk,
  input  logic              pixel_reset_reset_n,
  input  logic              cam_vsync,
  input  logic              cam_pixel_valid,
  input  logic [DATA_W-1:0] cam_pixel,
  output logic [DATA_W-1:0] src_data,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              src_valid,
  input  logic              src_ready,
  input  logic              stat_clear,
  output logic              stat_overflow,
  output logic [15:0]       stat_frames_done,
  output logic [7:0]        stat_frames_dropped,
  output pkt_state_t        dbg_state
);
  localparam int BW    = DATA_W + 2;
  localparam int XW    = cnt_w(FRAME_W);
  localparam int YW    = cnt_w(FRAME_H);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [XW-1:0]      X_LAST    = XW'(FRAME_W - 1);
  localparam logic [YW-1:0]      Y_LAST    = YW'(FRAME_H - 1);
  localparam logic [FIFO_AW:0]   HDR_LVL   = (FIFO_AW + 1)'(DEPTH - 2);
  localparam logic [DATA_W-1:0]  HDR_DATA  = DATA_W'(VIDEO_PKT_TYPE);
  localparam logic [BW-1:0]      HDR_BEAT  = {1'b0, 1'b1, HDR_DATA};
  localparam logic [BW-1:0]      PAD_BEAT  = {1'b1, 1'b0, {DATA_W{1'b0}}};

  pkt_state_t        r_state;
  pkt_state_t        w_state_nxt;
  logic              r_vsync_d;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_overflow;
  logic [15:0]       r_done;
  logic [7:0]        r_dropped;

  logic              w_vsync_rise;
  logic              w_push;
  logic [BW-1:0]     w_wbeat;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_AW:0]  w_level;
  logic [BW-1:0]     w_rbeat;
  logic              w_can_push;
  logic              w_room2;
  logic              w_last;
  logic              w_xy_clr;
  logic              w_xy_adv;
  logic              w_done_inc;
  logic              w_drop_inc;
  logic              w_ovf_set;

  // Handshake: a beat transfers on every cycle where src_valid && src_ready. While src_valid is high
  // and src_ready is low, src_data/sop/eop hold, because they come straight from the FIFO head.
  assign src_valid         = !w_empty;
  assign w_pop             = src_valid && src_ready;
  assign src_data          = w_empty ? '0 : w_rbeat[DATA_W-1:0];
  assign src_startofpacket = !w_empty && w_rbeat[DATA_W];
  assign src_endofpacket   = !w_empty && w_rbeat[DATA_W+1];

  assign w_vsync_rise = cam_vsync && !r_vsync_d;
  assign w_can_push   = !w_full || w_pop;
  assign w_room2      = (w_level <= HDR_LVL);
  assign w_last       = (r_x == X_LAST) && (r_y == Y_LAST);

  assign stat_overflow       = r_overflow;
  assign stat_frames_done    = r_done;
  assign stat_frames_dropped = r_dropped;
  assign dbg_state           = r_state;

  video_st_fifo #(.W(BW), .AW(FIFO_AW)) u_fifo (
    .clk     (pixel_clk_clk),
    .rst_n   (pixel_reset_reset_n),
    .i_push  (w_push),
    .i_wdata (w_wbeat),
    .i_pop   (w_pop),
    .o_rdata (w_rbeat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // vsync edge history. It resets high so that a vsync held high through reset release is not a frame start.
  always_ff @(posedge pixel_clk_clk or negedge pixel_reset_reset_n) begin
    if (!pixel_reset_reset_n) r_vsync_d <= 1'b1;
    else                      r_vsync_d <= cam_vsync;
  end

  // FSM state register.
  always_ff @(posedge pixel_clk_clk or negedge pixel_reset_reset_n) begin
    if (!pixel_reset_reset_n) r_state <= ST_IDLE;
    else                      r_state <= w_state_nxt;
  end

  // Next-state logic, FIFO writes and status events.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_wbeat     = '0;
    w_xy_clr    = 1'b0;
    w_xy_adv    = 1'b0;
    w_done_inc  = 1'b0;
    w_drop_inc  = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DROP: begin
        if (w_vsync_rise) begin
          if (w_room2) begin
            w_state_nxt = ST_HDR;
          end else begin
            w_state_nxt = ST_DROP;
            w_drop_inc  = 1'b1;
          end
        end
      end
      ST_HDR: begin
        // Pixels in this cycle are blanking and are ignored. If no slot is free, the frame is skipped.
        w_xy_clr = 1'b1;
        if (w_can_push) begin
          w_push      = 1'b1;
          w_wbeat     = HDR_BEAT;
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_DROP;
          w_drop_inc  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (w_vsync_rise) begin
          // Short frame: close the open packet now, or via TERM when no slot is free.
          if (w_can_push) begin
            w_push      = 1'b1;
            w_wbeat     = PAD_BEAT;
            w_drop_inc  = 1'b1;
            w_state_nxt = ST_HDR;
          end else begin
            w_state_nxt = ST_TERM;
          end
        end else if (cam_pixel_valid) begin
          if (w_can_push) begin
            w_push   = 1'b1;
            w_wbeat  = {w_last, 1'b0, cam_pixel};
            w_xy_adv = 1'b1;
            if (w_last) begin
              w_state_nxt = ST_IDLE;
              w_done_inc  = 1'b1;
            end
          end else begin
            w_ovf_set   = 1'b1;
            w_state_nxt = ST_TERM;
          end
        end
      end
      ST_TERM: begin
        if (w_can_push) begin
          w_push      = 1'b1;
          w_wbeat     = PAD_BEAT;
          w_drop_inc  = 1'b1;
          w_state_nxt = ST_DROP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pixel position within the frame. It is cleared when the header is issued and advances on each stored pixel.
  always_ff @(posedge pixel_clk_clk or negedge pixel_reset_reset_n) begin
    if (!pixel_reset_reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_xy_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_xy_adv) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Status: sticky overflow, wrapping done count, saturating drop count. stat_clear has priority.
  always_ff @(posedge pixel_clk_clk or negedge pixel_reset_reset_n) begin
    if (!pixel_reset_reset_n) begin
      r_overflow <= 1'b0;
      r_done     <= '0;
      r_dropped  <= '0;
    end else if (stat_clear) begin
      r_overflow <= 1'b0;
      r_done     <= '0;
      r_dropped  <= '0;
    end else begin
      if (w_ovf_set)                         r_overflow <= 1'b1;
      if (w_done_inc)                        r_done     <= r_done + 1'b1;
      if (w_drop_inc && r_dropped != 8'hFF)  r_dropped  <= r_dropped + 1'b1;
    end
  end

endmodule

// File: tb/tb_video_stream_packetizer.sv
// Bench for video_stream_packetizer with a 4x2 frame and an 8-entry FIFO.
`timescale 1ns/1ps
module tb_video_stream_packetizer;
  import video_st_pkg::*;

  localparam int DATA_W  = 24;
  localparam int FRAME_W = 4;
  localparam int FRAME_H = 2;
  localparam int FIFO_AW = 3;
  localparam int BW      = DATA_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              cam_vsync;
  logic              cam_pixel_valid;
  logic [DATA_W-1:0] cam_pixel;
  logic [DATA_W-1:0] src_data;
  logic              src_startofpacket;
  logic              src_endofpacket;
  logic              src_valid;
  logic              src_ready;
  logic              stat_clear;
  logic              stat_overflow;
  logic [15:0]       stat_frames_done;
  logic [7:0]        stat_frames_dropped;
  pkt_state_t        dbg_state;

  video_stream_packetizer #(
    .DATA_W(DATA_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .FIFO_AW(FIFO_AW)
  ) dut (
    .pixel_clk_clk       (clk),
    .pixel_reset_reset_n (rst_n),
    .cam_vsync           (cam_vsync),
    .cam_pixel_valid     (cam_pixel_valid),
    .cam_pixel           (cam_pixel),
    .src_data            (src_data),
    .src_startofpacket   (src_startofpacket),
    .src_endofpacket     (src_endofpacket),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .stat_clear          (stat_clear),
    .stat_overflow       (stat_overflow),
    .stat_frames_done    (stat_frames_done),
    .stat_frames_dropped (stat_frames_dropped),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  int   exp_done;
  int   exp_dropped;
  logic exp_ovf;
  int   ready_mode;   // 0 = hold low, 1 = hold high, 2 = random with at most 2 low cycles in a row
  int   low_run;
  int   sop_cnt = 0;
  int   eop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- expected-beat model ----------------
  task automatic exp_hdr();
    exp_q.push_back({1'b0, 1'b1, 24'h0});
  endtask
  task automatic exp_pix(input logic [DATA_W-1:0] v, input logic eop);
    exp_q.push_back({eop, 1'b0, v});
  endtask
  task automatic exp_pad();
    exp_q.push_back({1'b1, 1'b0, 24'h0});
  endtask
  // A complete frame: header, then FRAME_W*FRAME_H pixels starting at base, with EOP on the last pixel.
  task automatic exp_full_frame(input int base);
    exp_hdr();
    for (int i = 0; i < FRAME_W * FRAME_H; i++) exp_pix(24'(base + i), (i == FRAME_W * FRAME_H - 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: src_ready = 1'b0;
      1: src_ready = 1'b1;
      default: begin
        if (low_run >= 2) src_ready = 1'b1;
        else              src_ready = 1'($urandom_range(0, 1));
        low_run = src_ready ? 0 : low_run + 1;
      end
    endcase
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_pixel(input int v);
    cam_pixel_valid = 1'b1;
    cam_pixel       = 24'(v);
    tick();
    cam_pixel_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_pixel(base + i);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding want 0", name, exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic check_status(input string name);
    chk({name, "_done"}, 32'(stat_frames_done), 32'(exp_done));
    chk({name, "_dropped"}, 32'(stat_frames_dropped), 32'(exp_dropped));
    chk({name, "_ovf"}, 32'(stat_overflow), 32'(exp_ovf));
  endtask

  // ---------------- compare process ----------------
  logic [BW-1:0] cur_beat;
  logic [BW-1:0] prev_beat;
  logic [BW-1:0] want_beat;
  logic          prev_stall = 1'b0;

  // Outputs are sampled on the falling edge, away from the edge where the DUT updates.
  always @(negedge clk) begin
    cur_beat = {src_endofpacket, src_startofpacket, src_data};
    if (rst_n !== 1'b1) begin
      checks++;
      if (src_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid: got %b want 0", src_valid);
      end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (src_valid !== 1'b1 || cur_beat !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h want v=1 %h", src_valid, cur_beat, prev_beat);
        end
      end
      if (src_valid === 1'b1 && src_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h want none", cur_beat);
        end else begin
          want_beat = exp_q.pop_front();
          if (cur_beat !== want_beat) begin
            errors++;
            $display("FAIL beat: got %h want %h", cur_beat, want_beat);
          end
        end
        if (src_startofpacket) sop_cnt++;
        if (src_endofpacket)   eop_cnt++;
      end
      prev_stall = (src_valid === 1'b1) && (src_ready !== 1'b1);
      prev_beat  = cur_beat;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int sop0;
    int eop0;
    rst_n = 1'b0; cam_vsync = 1'b0; cam_pixel_valid = 1'b0; cam_pixel = '0;
    stat_clear = 1'b0; src_ready = 1'b0; ready_mode = 1; low_run = 0;
    exp_done = 0; exp_dropped = 0; exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(src_valid), 32'd0);
    chk("rst_data", 32'(src_data), 32'd0);
    chk("rst_sop_eop", 32'({src_startofpacket, src_endofpacket}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_status("rst");
    rst_n = 1'b1;
    tick(); tick();

    // Normal 4x2 frame with the sink always ready. Also checks the one-cycle pixel latency.
    exp_full_frame(1);
    vsync_pulse();
    send_pixel(1);
    chk("latency_valid", 32'(src_valid), 32'd1);
    chk("latency_data", 32'(src_data), 32'd1);
    send_frame(2, 7, 0);
    wait_drain("t1");
    exp_done = 1;
    check_status("t1");

    // Sink stalls for about 30 cycles. Header + 7 pixels fill the 8 entries, pixel 8 overflows, and the pad ends the packet.
    ready_mode = 0;
    tick();
    exp_hdr();
    for (int i = 1; i <= 7; i++) exp_pix(24'(10 + i), 1'b0);
    exp_pad();
    vsync_pulse();
    send_frame(11, 8, 0);
    chk("t2_ovf_during", 32'(stat_overflow), 32'd1);
    repeat (19) tick();
    ready_mode = 1;
    wait_drain("t2");
    exp_dropped = 1; exp_ovf = 1'b1;
    check_status("t2");
    exp_full_frame(21);
    vsync_pulse();
    send_frame(21, 8, 0);
    wait_drain("t2b");
    exp_done = 2;
    check_status("t2b");

    // Short frame: vsync after 5 pixels, then the following frame completes.
    exp_hdr();
    for (int i = 0; i < 5; i++) exp_pix(24'(31 + i), 1'b0);
    exp_pad();
    exp_full_frame(41);
    vsync_pulse();
    send_frame(31, 5, 0);
    vsync_pulse();
    send_frame(41, 8, 0);
    wait_drain("t3");
    exp_dropped = 2; exp_done = 3;
    check_status("t3");

    // Long frame: 10 pixels are sent, and the last 2 are discarded.
    exp_full_frame(51);
    vsync_pulse();
    send_frame(51, 10, 0);
    wait_drain("t4");
    exp_done = 4;
    check_status("t4");

    // 20 frames with a pixel every 3rd cycle and a random ready.
    sop0 = sop_cnt; eop0 = eop_cnt;
    ready_mode = 2;
    for (int f = 0; f < 20; f++) begin
      exp_full_frame(100 + f * 8);
      vsync_pulse();
      send_frame(100 + f * 8, 8, 2);
      repeat (6) tick();
    end
    wait_drain("t5");
    ready_mode = 1;
    tick();
    exp_done = 24;
    check_status("t5");
    chk("t5_sop_count", 32'(sop_cnt - sop0), 32'd20);
    chk("t5_eop_count", 32'(eop_cnt - eop0), 32'd20);

    // A stat_clear pulse on its own.
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    tick();
    exp_done = 0; exp_dropped = 0; exp_ovf = 1'b0;
    check_status("t6");

    // Reset mid-frame with beats still queued, and vsync held high across reset release.
    ready_mode = 0;
    tick();
    vsync_pulse();
    send_frame(200, 3, 0);
    chk("t7_pre_valid", 32'(src_valid), 32'd1);
    rst_n = 1'b0;
    cam_vsync = 1'b1;
    tick();
    chk("t7_in_reset_valid", 32'(src_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    ready_mode = 1;
    tick(); tick(); tick();
    chk("t7_held_vsync_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t7_post_valid", 32'(src_valid), 32'd0);
    cam_vsync = 1'b0;
    tick();
    exp_full_frame(210);
    vsync_pulse();
    send_frame(210, 8, 0);
    wait_drain("t7");
    exp_done = 1; exp_dropped = 0; exp_ovf = 1'b0;
    check_status("t7");

    // stat_clear in the same cycle as frame completion takes priority over the increment.
    exp_full_frame(220);
    vsync_pulse();
    send_frame(220, 7, 0);
    stat_clear = 1'b1;
    send_pixel(227);
    stat_clear = 1'b0;
    wait_drain("t8");
    exp_done = 0;
    check_status("t8");
    exp_full_frame(230);
    vsync_pulse();
    send_frame(230, 8, 0);
    wait_drain("t8b");
    exp_done = 1;
    check_status("t8b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
